fft_bfu_pipe: RTL and testbench

- Pipelined, handshaked radix-2 DIT butterfly for the tuner FFT datapath. Computes aout = a + w*b and bout = a - w*b on packed {re,im} complex words.
- Sits between the twiddle ROM / sample RAM read ports and the RAM write-back. It adds the following behaviour:
  - parametrised widths;
  - 3-cycle pipeline with valid/ready flow control;
  - convergent-free half-up rounding;
  - optional per-pass divide-by-2 scaling;
  - saturation with a sticky overflow flag;
  - a passthrough tag that carries the write-back address.

---
 rtl/fft_bfu_pipe.sv | 184 ++++++++++++++++++
 tb/tb_fft_bfu_pipe.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfu_pipe.sv
// Radix-2 DIT butterfly, three register stages with valid/ready flow control.
// aout = a + w*b, bout = a - w*b on packed {re,im} words; saturating, optional /2 scaling.
module fft_bfu_pipe #(
    parameter int BIT_WIDTH = 16,
    parameter int TW_WIDTH  = 16,
    parameter int TAG_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*BIT_WIDTH-1:0] a,
    input  logic [2*BIT_WIDTH-1:0] b,
    input  logic [2*TW_WIDTH-1:0]  twiddle,
    input  logic                   scale,
    input  logic [TAG_WIDTH-1:0]   tag_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*BIT_WIDTH-1:0] aout,
    output logic [2*BIT_WIDTH-1:0] bout,
    output logic [TAG_WIDTH-1:0]   tag_out,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam int PW = BIT_WIDTH + TW_WIDTH;   // full product width
    localparam int GW = PW + 1;                 // product sum with guard bit
    localparam int TT = BIT_WIDTH + 2;          // rounded twiddle product
    localparam int SW = BIT_WIDTH + 3;          // butterfly sum width

    localparam logic [GW-1:0] RND =
        {{(GW-TW_WIDTH+1){1'b0}}, 1'b1, {(TW_WIDTH-2){1'b0}}};
    localparam logic signed [SW-1:0] ONE_S = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] MAX_S =
        {{(SW-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_S =
        {{(SW-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    logic adv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage 1: operands sign-extended so w = -1 and b = -full-scale multiply exactly
    logic signed [PW-1:0] b_re_x, b_im_x, w_re_x, w_im_x;
    logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;

    assign b_re_x = {{TW_WIDTH{b[2*BIT_WIDTH-1]}}, b[2*BIT_WIDTH-1:BIT_WIDTH]};
    assign b_im_x = {{TW_WIDTH{b[BIT_WIDTH-1]}}, b[BIT_WIDTH-1:0]};
    assign w_re_x = {{BIT_WIDTH{twiddle[2*TW_WIDTH-1]}}, twiddle[2*TW_WIDTH-1:TW_WIDTH]};
    assign w_im_x = {{BIT_WIDTH{twiddle[TW_WIDTH-1]}}, twiddle[TW_WIDTH-1:0]};

    assign m_rr = b_re_x * w_re_x;
    assign m_ii = b_im_x * w_im_x;
    assign m_ri = b_re_x * w_im_x;
    assign m_ir = b_im_x * w_re_x;

    logic                   s1_valid;
    logic [2*BIT_WIDTH-1:0] s1_a;
    logic                   s1_scale;
    logic [TAG_WIDTH-1:0]   s1_tag;
    logic signed [PW-1:0]   s1_rr, s1_ii, s1_ri, s1_ir;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_scale <= 1'b0;
            s1_tag   <= '0;
            s1_rr    <= '0;
            s1_ii    <= '0;
            s1_ri    <= '0;
            s1_ir    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_a     <= a;
            s1_scale <= scale;
            s1_tag   <= tag_in;
            s1_rr    <= m_rr;
            s1_ii    <= m_ii;
            s1_ri    <= m_ri;
            s1_ir    <= m_ir;
        end
    end

    // Stage 2: complex product, round half-up, drop the Q1.(TW_WIDTH-1) fraction
    logic signed [GW-1:0] p_re, p_im, r_re, r_im;
    logic signed [TT-1:0] t_re_n, t_im_n;

    assign p_re   = {s1_rr[PW-1], s1_rr} - {s1_ii[PW-1], s1_ii};
    assign p_im   = {s1_ri[PW-1], s1_ri} + {s1_ir[PW-1], s1_ir};
    assign r_re   = p_re + RND;
    assign r_im   = p_im + RND;
    assign t_re_n = TT'(r_re >>> (TW_WIDTH-1));
    assign t_im_n = TT'(r_im >>> (TW_WIDTH-1));

    logic                   s2_valid;
    logic [2*BIT_WIDTH-1:0] s2_a;
    logic                   s2_scale;
    logic [TAG_WIDTH-1:0]   s2_tag;
    logic signed [TT-1:0]   s2_t_re, s2_t_im;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_a     <= '0;
            s2_scale <= 1'b0;
            s2_tag   <= '0;
            s2_t_re  <= '0;
            s2_t_im  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_a     <= s1_a;
            s2_scale <= s1_scale;
            s2_tag   <= s1_tag;
            s2_t_re  <= t_re_n;
            s2_t_im  <= t_im_n;
        end
    end

    // Stage 3: add/subtract, optional rounded halving, clamp; MSB of result flags saturation
    function automatic logic [BIT_WIDTH:0] scale_sat(input logic signed [SW-1:0] x,
                                                     input logic scl);
        logic signed [SW-1:0] inc;
        logic signed [SW-1:0] y;
        logic [BIT_WIDTH:0]   res;
        inc = x + ONE_S;
        y   = scl ? (inc >>> 1) : x;
        if (y > MAX_S)
            res = {1'b1, BIT_WIDTH'(MAX_S)};
        else if (y < MIN_S)
            res = {1'b1, BIT_WIDTH'(MIN_S)};
        else
            res = {1'b0, BIT_WIDTH'(y)};
        return res;
    endfunction

    logic signed [SW-1:0] a_re_x, a_im_x, t_re_x, t_im_x;
    logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
    logic [BIT_WIDTH:0]   q_sre, q_sim, q_dre, q_dim;
    logic                 sat_any;

    assign a_re_x = {{(SW-BIT_WIDTH){s2_a[2*BIT_WIDTH-1]}}, s2_a[2*BIT_WIDTH-1:BIT_WIDTH]};
    assign a_im_x = {{(SW-BIT_WIDTH){s2_a[BIT_WIDTH-1]}}, s2_a[BIT_WIDTH-1:0]};
    assign t_re_x = {s2_t_re[TT-1], s2_t_re};
    assign t_im_x = {s2_t_im[TT-1], s2_t_im};

    assign sum_re = a_re_x + t_re_x;
    assign sum_im = a_im_x + t_im_x;
    assign dif_re = a_re_x - t_re_x;
    assign dif_im = a_im_x - t_im_x;

    assign q_sre = scale_sat(sum_re, s2_scale);
    assign q_sim = scale_sat(sum_im, s2_scale);
    assign q_dre = scale_sat(dif_re, s2_scale);
    assign q_dim = scale_sat(dif_im, s2_scale);

    assign sat_any = q_sre[BIT_WIDTH] | q_sim[BIT_WIDTH] | q_dre[BIT_WIDTH] | q_dim[BIT_WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            aout      <= '0;
            bout      <= '0;
            tag_out   <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            aout      <= {q_sre[BIT_WIDTH-1:0], q_sim[BIT_WIDTH-1:0]};
            bout      <= {q_dre[BIT_WIDTH-1:0], q_dim[BIT_WIDTH-1:0]};
            tag_out   <= s2_tag;
        end
    end

    // Set only when a real word enters the output stage; clear wins a same-cycle set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ovf <= 1'b0;
        else if (ovf_clr)
            ovf <= 1'b0;
        else if (adv && s2_valid && sat_any)
            ovf <= 1'b1;
    end

endmodule

// File: tb/tb_fft_bfu_pipe.sv
// Scoreboard bench for fft_bfu_pipe: accepted words push a model result, the
// output monitor pops and compares; scenario tasks add directed checks.
module tb_fft_bfu_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] twiddle = '0;
    logic        scale = 1'b0;
    logic [10:0] tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] aout;
    logic [31:0] bout;
    logic [10:0] tag_out;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    fft_bfu_pipe #(.BIT_WIDTH(16), .TW_WIDTH(16), .TAG_WIDTH(11)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .twiddle(twiddle), .scale(scale), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .aout(aout), .bout(bout),
        .tag_out(tag_out), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] aout;
        logic [31:0] bout;
        logic [10:0] tag;
    } exp_t;

    exp_t sb[$];
    int   rx_tags[$];
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;

    function automatic logic [15:0] sat_model(input longint v, input bit scl);
        longint y;
        y = scl ? ((v + 1) >>> 1) : v;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return 16'(y);
    endfunction

    function automatic exp_t model(input int ar, input int ai, input int br, input int bi,
                                   input int wr, input int wi, input bit scl, input int tg);
        exp_t   e;
        longint pre, pim, tre, tim;
        pre = longint'(br) * longint'(wr) - longint'(bi) * longint'(wi);
        pim = longint'(br) * longint'(wi) + longint'(bi) * longint'(wr);
        tre = (pre + 16384) >>> 15;
        tim = (pim + 16384) >>> 15;
        e.aout = {sat_model(ar + tre, scl), sat_model(ai + tim, scl)};
        e.bout = {sat_model(ar - tre, scl), sat_model(ai - tim, scl)};
        e.tag  = 11'(tg);
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            rx_tags.push_back(int'(tag_out));
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got tag %0d aout=%h, required no output", tag_out, aout);
            end else begin
                mon_e = sb.pop_front();
                if ({aout, bout, tag_out} !== {mon_e.aout, mon_e.bout, mon_e.tag}) begin
                    errors++;
                    $display("FAIL sb_result: got aout=%h bout=%h tag=%0d, required aout=%h bout=%h tag=%0d",
                             aout, bout, tag_out, mon_e.aout, mon_e.bout, mon_e.tag);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi, input bit scl, input int tg);
        bit acc;
        int n;
        a = {16'(ar), 16'(ai)};
        b = {16'(br), 16'(bi)};
        twiddle = {16'(wr), 16'(wi)};
        scale = scl;
        tag_in = 11'(tg);
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                sb.push_back(model(ar, ai, br, bi, wr, wi, scl, tg));
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: tag %0d not accepted, got in_ready=%b, required 1", tg, in_ready);
        end
    endtask

    task automatic wait_out(output bit ok);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
        if (aout !== 32'h0)     begin errors++; $display("FAIL reset_aout: got %h, required 0", aout); end
        if (bout !== 32'h0)     begin errors++; $display("FAIL reset_bout: got %h, required 0", bout); end
        if (tag_out !== 11'h0)  begin errors++; $display("FAIL reset_tag: got %0d, required 0", tag_out); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_single();
        logic [31:0] ea, eb;
        ea = {16'(3000), 16'(-500)};
        eb = {16'(1000), 16'(-500)};
        send(2000, -500, 1000, 0, 32767, 0, 1'b0, 5);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_edge1: got out_valid=%b, required 0", out_valid); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_edge2: got out_valid=%b, required 0", out_valid); end
        @(posedge clk); #1;
        checks += 5;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_edge3: got out_valid=%b, required 1", out_valid); end
        if (aout !== ea)        begin errors++; $display("FAIL single_aout: got %h, required %h", aout, ea); end
        if (bout !== eb)        begin errors++; $display("FAIL single_bout: got %h, required %h", bout, eb); end
        if (tag_out !== 11'd5)  begin errors++; $display("FAIL single_tag: got %0d, required 5", tag_out); end
        if (ovf !== 1'b0)       begin errors++; $display("FAIL single_ovf: got %b, required 0", ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_twiddle_j();
        bit ok;
        logic [31:0] ea, eb;
        ea = {16'(200), 16'(-100)};
        eb = {16'(-200), 16'(100)};
        send(0, 0, 100, 200, 0, -32768, 1'b0, 1);
        wait_out(ok);
        checks += 3;
        if (!ok)         begin errors++; $display("FAIL twj_timeout: got out_valid=0, required 1"); end
        if (aout !== ea) begin errors++; $display("FAIL twj_aout: got %h, required %h", aout, ea); end
        if (bout !== eb) begin errors++; $display("FAIL twj_bout: got %h, required %h", bout, eb); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        bit ok;
        send(32000, 0, 32000, 0, 32767, 0, 1'b0, 2);
        wait_out(ok);
        checks += 4;
        if (!ok)                  begin errors++; $display("FAIL sat_timeout: got out_valid=0, required 1"); end
        if (aout[31:16] !== 16'd32767) begin errors++; $display("FAIL sat_aout_re: got %0d, required 32767", $signed(aout[31:16])); end
        if (bout[31:16] !== 16'd1)     begin errors++; $display("FAIL sat_bout_re: got %0d, required 1", $signed(bout[31:16])); end
        if (ovf !== 1'b1)         begin errors++; $display("FAIL sat_ovf_set: got %b, required 1", ovf); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky: got %b, required 1", ovf); end
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_clr: got %b, required 0", ovf); end
    endtask

    task automatic test_scaling();
        bit ok;
        send(32000, 0, 32000, 0, 32767, 0, 1'b1, 3);
        wait_out(ok);
        checks += 4;
        if (!ok)                       begin errors++; $display("FAIL scl_timeout: got out_valid=0, required 1"); end
        if (aout[31:16] !== 16'd32000) begin errors++; $display("FAIL scl_aout_re: got %0d, required 32000", $signed(aout[31:16])); end
        if (bout[31:16] !== 16'd1)     begin errors++; $display("FAIL scl_bout_re: got %0d, required 1", $signed(bout[31:16])); end
        if (ovf !== 1'b0)              begin errors++; $display("FAIL scl_ovf: got %b, required 0", ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_ovf_clr_priority();
        send(32000, 0, 32000, 0, 32767, 0, 1'b0, 4);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL clrpri_valid: got %b, required 1", out_valid); end
        if (ovf !== 1'b0)       begin errors++; $display("FAIL clrpri_ovf: got %b, required 0", ovf); end
        @(posedge clk); #1;
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL clrpri_after: got %b, required 0", ovf); end
        // saturating operands presented with in_valid low only fill bubbles
        a = {16'(32000), 16'(0)};
        b = {16'(32000), 16'(0)};
        twiddle = {16'(32767), 16'(0)};
        scale = 1'b0;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks += 2;
        if (ovf !== 1'b0)       begin errors++; $display("FAIL bubble_ovf: got %b, required 0", ovf); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b, required 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int   t_ar[5] = '{1234, -32768, 32767, 0, 100};
        int   t_ai[5] = '{-77, 500, -32768, 32767, -7};
        int   t_br[5] = '{4000, -1200, 32767, -32768, -32768};
        int   t_bi[5] = '{-3000, 99, -32768, 1, 5};
        int   t_wr[5] = '{23170, -32768, 32767, 0, -32768};
        int   t_wi[5] = '{-23170, 0, -32768, 32767, 0};
        bit   t_sc[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_t e0;
        int   n;
        rx_tags.delete();
        out_ready = 1'b1;
        e0 = model(t_ar[0], t_ai[0], t_br[0], t_bi[0], t_wr[0], t_wi[0], t_sc[0], 0);
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(t_ar[i], t_ai[i], t_br[i], t_bi[i], t_wr[i], t_wi[i], t_sc[i], i);
            end
            begin
                int k;
                k = 0;
                while (!out_valid && k < 20) begin
                    @(posedge clk); #1;
                    k++;
                end
                out_ready = 1'b0;
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got out_valid=%b, required 1", out_valid); end
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    checks += 3;
                    if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready c%0d: got %b, required 0", c, in_ready); end
                    if (tag_out !== 11'd0)  begin errors++; $display("FAIL bp_tag c%0d: got %0d, required 0", c, tag_out); end
                    if (aout !== e0.aout)   begin errors++; $display("FAIL bp_aout c%0d: got %h, required %h", c, aout, e0.aout); end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        checks++;
        if (rx_tags.size() != 5) begin
            errors++;
            $display("FAIL bp_count: got %0d words, required 5", rx_tags.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rx_tags[i] != i) begin errors++; $display("FAIL bp_order %0d: got tag %0d, required %0d", i, rx_tags[i], i); end
            end
        end
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
    endtask

    task automatic test_random_stream();
        bit done;
        int n;
        done = 1'b0;
        rx_tags.delete();
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                         int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                         int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                         1'($urandom_range(0, 1)), 100 + i);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        checks++;
        if (rx_tags.size() != 40) begin
            errors++;
            $display("FAIL rand_count: got %0d words, required 40", rx_tags.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                checks++;
                if (rx_tags[i] != 100 + i) begin errors++; $display("FAIL rand_order %0d: got tag %0d, required %0d", i, rx_tags[i], 100 + i); end
            end
        end
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        bit seen;
        out_ready = 1'b1;
        send(32000, 0, 32000, 0, 32767, 0, 1'b0, 10);
        send(32000, 0, 32000, 0, 32767, 0, 1'b0, 11);
        send(32000, 0, 32000, 0, 32767, 0, 1'b0, 12);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b, required 1", out_valid); end
        if (ovf !== 1'b1)       begin errors++; $display("FAIL arst_pre_ovf: got %b, required 1", ovf); end
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b, required 0", out_valid); end
        if (ovf !== 1'b0)       begin errors++; $display("FAIL arst_ovf: got %b, required 0", ovf); end
        @(posedge clk); #3;
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL arst_flush: got out_valid=1 after reset, required 0"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_twiddle_j();
        test_saturation();
        test_scaling();
        test_ovf_clr_priority();
        test_back_to_back();
        test_random_stream();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
